// File: rtl/sd_pkg.sv
// sd_pkg: shared arbiter state encoding, SD op-codes and block size.
package sd_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, XFER, DONE} arb_state_t;
    localparam logic OP_READ     = 1'b0;
    localparam logic OP_WRITE    = 1'b1;
    localparam int   BLOCK_BYTES = 512;
endpackage

// File: rtl/sd_block_arbiter_if.sv
// sd_block_arbiter_if: bus between the block arbiter and the SD controller.
//   master (arbiter): drives sd_execute, sd_op_code, sd_block_address, sd_outgoing_byte;
//                     receives sd_incoming_byte, sd_finished_byte, sd_finished_block, sd_busy.
//   slave (controller): the mirror image.
interface sd_block_arbiter_if;
    logic        sd_execute;
    logic        sd_op_code;
    logic [31:0] sd_block_address;
    logic [7:0]  sd_outgoing_byte;
    logic [7:0]  sd_incoming_byte;
    logic        sd_finished_byte;
    logic        sd_finished_block;
    logic        sd_busy;
    modport master (
        output sd_execute, sd_op_code, sd_block_address, sd_outgoing_byte,
        input  sd_incoming_byte, sd_finished_byte, sd_finished_block, sd_busy
    );
    modport slave (
        input  sd_execute, sd_op_code, sd_block_address, sd_outgoing_byte,
        output sd_incoming_byte, sd_finished_byte, sd_finished_block, sd_busy
    );
endinterface

// File: rtl/sd_req_slot.sv
// sd_req_slot: pending-request latch, busy flag and sticky error for one requester.
//   clk/rst: falling-edge clock, async active-high reset.
//   execute/op_code/block_address: request pulse and its parameters.
//   release_slot: transaction finished or aborted; set_error: mark it failed.
//   busy/error/lat_op/lat_address: slot state towards requester and arbiter.
module sd_req_slot (
    input  logic        clk,
    input  logic        rst,
    input  logic        execute,
    input  logic        op_code,
    input  logic [31:0] block_address,
    input  logic        release_slot,
    input  logic        set_error,
    output logic        busy,
    output logic        error,
    output logic        lat_op,
    output logic [31:0] lat_address
);
    // a request arriving on the edge that frees the slot is taken, not dropped
    logic accept;
    assign accept = execute && (!busy || release_slot);
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            error       <= 1'b0;
            lat_op      <= 1'b0;
            lat_address <= '0;
        end else begin
            busy  <= accept || (busy && !release_slot);
            // a failure reported on the same edge as a new accept stays visible
            error <= set_error || (error && !accept);
            if (accept) begin
                lat_op      <= op_code;
                lat_address <= block_address;
            end
        end
    end
endmodule

// File: rtl/sd_block_arbiter.sv
// sd_block_arbiter: round-robin arbiter sharing one SD controller between two requesters.
//   clk/rst: falling-edge clock, async active-high reset; sd_ready: card init complete.
//   rN_*: per-requester request inputs and busy/strobe/error outputs.
//   incoming_byte: read data, valid with the granted rN_finished_byte.
//   sd: master side of the SD controller bus.
module sd_block_arbiter
    import sd_pkg::*;
#(
    parameter logic [23:0] WDOG_CYCLES = 24'd12_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sd_ready,
    input  logic        r0_execute,
    input  logic        r0_op_code,
    input  logic [31:0] r0_block_address,
    input  logic [7:0]  r0_outgoing_byte,
    output logic        r0_busy,
    output logic        r0_finished_byte,
    output logic        r0_finished_block,
    output logic        r0_error,
    input  logic        r1_execute,
    input  logic        r1_op_code,
    input  logic [31:0] r1_block_address,
    input  logic [7:0]  r1_outgoing_byte,
    output logic        r1_busy,
    output logic        r1_finished_byte,
    output logic        r1_finished_block,
    output logic        r1_error,
    output logic [7:0]  incoming_byte,
    sd_block_arbiter_if.master sd
);
    arb_state_t  state, state_n;
    logic        gnt, gnt_n, last;
    logic [9:0]  byte_cnt;
    logic [23:0] wdog;
    logic [1:0]  busy, error, lat_op, sel, rel, set_err, fin;
    logic [31:0] lat_addr [2];
    logic        sd_op;
    logic [31:0] sd_addr;
    logic        xfer, wdog_hit, blk_ok;

    sd_req_slot u_slot0 (
        .clk(clk), .rst(rst), .execute(r0_execute), .op_code(r0_op_code),
        .block_address(r0_block_address), .release_slot(rel[0]), .set_error(set_err[0]),
        .busy(busy[0]), .error(error[0]), .lat_op(lat_op[0]), .lat_address(lat_addr[0])
    );
    sd_req_slot u_slot1 (
        .clk(clk), .rst(rst), .execute(r1_execute), .op_code(r1_op_code),
        .block_address(r1_block_address), .release_slot(rel[1]), .set_error(set_err[1]),
        .busy(busy[1]), .error(error[1]), .lat_op(lat_op[1]), .lat_address(lat_addr[1])
    );

    assign xfer     = state == XFER;
    assign wdog_hit = state != IDLE && wdog == WDOG_CYCLES - 24'd1;
    assign blk_ok   = byte_cnt == 10'(BLOCK_BYTES);
    // one-hot of the held grant; empty while idle so nothing leaks to either requester
    assign sel      = {gnt, !gnt} & {2{state != IDLE}};
    assign rel      = sel & {2{(state == DONE && !sd.sd_busy) || wdog_hit}};
    assign set_err  = sel & {2{(xfer && sd.sd_finished_block && !blk_ok) || wdog_hit}};

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        unique case (state)
            IDLE: if (sd_ready && |busy) begin
                state_n = ISSUE;
                gnt_n   = &busy ? !last : busy[1];
            end
            ISSUE:     state_n = WAIT_BUSY;
            WAIT_BUSY: state_n = sd.sd_busy ? XFER : WAIT_BUSY;
            XFER:      state_n = sd.sd_finished_block ? DONE : XFER;
            DONE:      state_n = sd.sd_busy ? DONE : IDLE;
            default:   state_n = IDLE;
        endcase
        if (wdog_hit) state_n = IDLE;
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last     <= 1'b1;
            byte_cnt <= '0;
            wdog     <= '0;
            fin      <= '0;
            sd_op    <= 1'b0;
            sd_addr  <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            last     <= |rel ? gnt : last;
            byte_cnt <= state == ISSUE ? '0 : xfer && sd.sd_finished_byte ? byte_cnt + 10'd1 : byte_cnt;
            wdog     <= state == IDLE ? '0 : wdog + 24'd1;
            // registered so the strobe lands in the first DONE cycle as a clean pulse
            fin      <= sel & {2{xfer && sd.sd_finished_block && blk_ok}};
            if (state == IDLE && state_n == ISSUE) begin
                sd_op   <= lat_op[gnt_n];
                sd_addr <= lat_addr[gnt_n];
            end
        end
    end

    assign sd.sd_execute       = state == ISSUE;
    assign sd.sd_op_code       = sd_op;
    assign sd.sd_block_address = sd_addr;
    assign sd.sd_outgoing_byte = state == IDLE ? 8'h00 : gnt ? r1_outgoing_byte : r0_outgoing_byte;
    assign incoming_byte       = xfer ? sd.sd_incoming_byte : 8'h00;
    assign {r1_finished_byte, r0_finished_byte}   = sel & {2{xfer && sd.sd_finished_byte}};
    assign {r1_finished_block, r0_finished_block} = fin;
    assign {r1_busy, r0_busy}   = busy;
    assign {r1_error, r0_error} = error;
endmodule

// File: doc/sd_block_arbiter.md
SD_BLOCK_ARBITER -- requirements
Module: sd_block_arbiter

Interface
REQ-001 Parameter WDOG_CYCLES, default 24'd12_000_000, SHALL set the clk cycles one transaction may take before abort.
REQ-002 clk  in  1  system clock; all state SHALL update on the falling edge of clk, matching the SD controller.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 sd_ready  in  1  high once the SD card init has completed; no grant SHALL issue while low.
REQ-005 Per requester rN, N in {0,1}, the following ports SHALL exist.
  - rN_execute  in  1  one-cycle request pulse.
  - rN_op_code  in  1  0 = READ, 1 = WRITE.
  - rN_block_address  in  32  target sector.
  - rN_outgoing_byte  in  8  write data.
  - rN_busy  out  1  request pending or in flight.
  - rN_finished_byte  out  1  byte strobe.
  - rN_finished_block  out  1  block-done strobe.
  - rN_error  out  1  sticky error, cleared on the next accepted rN_execute.
REQ-006 incoming_byte  out  8  SHALL be shared read data, valid with the granted rN_finished_byte.
REQ-007 sd_execute, sd_op_code, sd_block_address[31:0] and sd_outgoing_byte[7:0] SHALL be outputs to the SD controller.
REQ-008 sd_incoming_byte[7:0], sd_finished_byte, sd_finished_block and sd_busy SHALL be inputs from the SD controller.

Function
REQ-009 rN_execute while rN_busy=0 SHALL latch op_code and address into pending slot N and set rN_busy the same edge; rN_execute while rN_busy=1 SHALL be ignored.
REQ-010 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY, XFER and DONE.
REQ-011 IDLE: with sd_ready=1 and any slot pending, the FSM SHALL grant and go to ISSUE.
  - One slot pending: grant it.
  - Both pending: grant the slot not granted last (round-robin); after reset r0 wins.
REQ-012 ISSUE SHALL drive sd_op_code and sd_block_address from the granted slot and assert sd_execute for exactly one cycle, then go to WAIT_BUSY.
REQ-013 sd_op_code and sd_block_address SHALL stay constant from ISSUE until DONE.
REQ-014 WAIT_BUSY SHALL go to XFER on the first cycle sd_busy=1.
REQ-015 XFER SHALL mirror sd_finished_byte to the granted rN_finished_byte only, and count bytes in a 10-bit counter (0..512).
REQ-016 sd_outgoing_byte SHALL be the granted rN_outgoing_byte combinationally, and 8'h00 when no grant is held.
REQ-017 XFER SHALL go to DONE on sd_finished_block.
  - Count == 512: pulse the granted rN_finished_block one cycle.
  - Count != 512: set rN_error instead of pulsing rN_finished_block.
REQ-018 DONE SHALL wait for sd_busy=0, then clear the slot's rN_busy, record last-grant and return to IDLE.
REQ-019 A watchdog SHALL count cycles outside IDLE; on reaching WDOG_CYCLES it SHALL set rN_error, clear rN_busy and go to IDLE.
REQ-020 A new rN_execute on the same edge rN_busy clears SHALL be accepted.
REQ-021 Simultaneous r0_execute and r1_execute SHALL latch both slots and serve them back to back.
REQ-022 Non-granted strobes SHALL stay 0 at all times.
REQ-023 sd_ready falling mid-transaction SHALL NOT abort the transaction; it SHALL only block new grants.

Reset
REQ-024 rst SHALL force the following values.
  - FSM = IDLE, slots empty, last-grant = r1, counters = 0.
  - All rN_* outputs = 0, sd_execute = 0, sd_op_code = 0, sd_block_address = 0.
REQ-025 rst mid-transaction SHALL drop the grant without a completion strobe; the requester SHALL reissue.

Structure
REQ-026 State encodings, op-code values (READ=0, WRITE=1) and BLOCK_BYTES=512 SHALL reside in the shared sd_pkg.
REQ-027 One sub-module, sd_req_slot (latch, busy and error for one requester), SHALL be instantiated twice.

Verification
REQ-028 sd_ready=1; r0 READ at 0x0000_0800 -> one sd_execute pulse, address 0x800, 512 r0_finished_byte, one r0_finished_block, r0_busy drops; r1 strobes stay 0.
REQ-029 r0 and r1 execute on the same cycle -> r0 served first, then r1; the next simultaneous pair -> r1 first.
REQ-030 Model ends the block after 300 bytes -> r0_error=1, no r0_finished_block; the next r0_execute clears r0_error.
REQ-031 WDOG_CYCLES=1000 with sd_busy stuck high -> at cycle 1000 r1_error=1, r1_busy=0, FSM returns to IDLE.
REQ-032 rst at byte 100 of a WRITE -> all outputs 0 within one cycle, and a fresh request after rst completes normally.
REQ-033 sd_ready=0 with r0 pending -> no sd_execute; sd_ready rising -> sd_execute on the next ISSUE cycle.
